// File: rtl/ipic_lite_pkg.sv
// ipic_lite_pkg: shared constants and state encoding for the IPIC-lite arbiter.
package ipic_lite_pkg;

  // Transaction type codes understood by the IPIC engine.
  localparam logic [2:0] SINGLE_RD = 3'd2;
  localparam logic [2:0] SINGLE_WR = 3'd3;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ipic_lite_arbiter_if.sv
// ipic_lite_arbiter_if: requester-side and engine-side signals of the arbiter.
// slave  = the arbiter's view; master = the surrounding requesters/engine.
interface ipic_lite_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 4
);
  // Requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         req_rdata;
  logic                      req_err;
  // Engine side
  logic [2:0]                ipic_type;
  logic                      ipic_start;
  logic                      ipic_done;
  logic [ADDR_W-1:0]         read_addr;
  logic [ADDR_W-1:0]         write_addr;
  logic [DATA_W-1:0]         write_data;
  logic [DATA_W-1:0]         single_read_data;
  // Status
  logic                      timeout_flag;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, ipic_done, single_read_data,
    output req_done, req_rdata, req_err, ipic_type, ipic_start,
           read_addr, write_addr, write_data, timeout_flag
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, ipic_done, single_read_data,
    input  req_done, req_rdata, req_err, ipic_type, ipic_start,
           read_addr, write_addr, write_data, timeout_flag
  );
endinterface

// File: rtl/ipic_rr_grant.sv
// ipic_rr_grant: combinational round-robin pick. The search starts at ptr and
// wraps modulo NUM_REQ; the first requester found high gets the one-hot grant.
module ipic_rr_grant #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);
  int   cand;
  logic found;

  // Walk the requesters from ptr upwards, keep the first active one.
  always_comb begin
    // NOTE: every variable of this block gets a default before any branch,
    // so no path leaves it holding an old value and no latch is inferred.
    grant = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ipic_lite_arbiter.sv
// ipic_lite_arbiter: round-robin arbiter funnelling C_NUM_REQ single-beat
// requesters into one IPIC engine (IDLE -> ISSUE -> RESP -> GAP).
// Optional feature: define IPIC_ARB_TIMEOUT_EN to add an ISSUE watchdog that
// aborts a hung engine access with req_err and a sticky timeout_flag.
module ipic_lite_arbiter
  import ipic_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_NATIVE_DATA_WIDTH = 32,
  parameter int C_NUM_REQ           = 4,
  parameter int C_TIMEOUT_CYCLES    = 1024
) (
  input logic                clk,
  input logic                reset_n,
  ipic_lite_arbiter_if.slave bus
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_NATIVE_DATA_WIDTH;
  localparam int IDX_W = $clog2(C_NUM_REQ);

  if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || C_TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ipic_lite_arbiter: C_NUM_REQ must be 2..8 and C_TIMEOUT_CYCLES >= 2");
  end

  arb_state_t           state, next_state;
  logic [C_NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     ptr_q;
  logic                 grant_fire;
  logic                 issue_ok;
  logic                 issue_tmo;
  logic                 tmo_hit;
  logic                 halted;
  logic [2:0]           type_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;
  logic [DW-1:0]        rdata_q;
  logic                 start_q;

  ipic_rr_grant #(.NUM_REQ(C_NUM_REQ)) u_rr_grant (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant_oh)
  );

  // Convert the one-hot grant into an index for slicing the packed buses.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (grant_oh[i]) grant_idx = IDX_W'(i);
    end
  end

  // Next-state and per-edge event decode.
  always_comb begin
    next_state = state;
    grant_fire = 1'b0;
    issue_ok   = 1'b0;
    issue_tmo  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid && !halted) begin
          grant_fire = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ipic_done) begin
          issue_ok   = 1'b1;
          next_state = RESP;
        end else if (tmo_hit) begin
          issue_tmo  = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = GAP;
      // Let the engine drop ipic_done before a new start can be raised.
      GAP:     if (!bus.ipic_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Grant latch, round-robin pointer, engine start level and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, independent of statement order.
      if (grant_fire) begin
        grant_q <= grant_idx;
        ptr_q   <= (grant_idx == IDX_W'(C_NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        type_q  <= bus.req_wr[grant_idx] ? SINGLE_WR : SINGLE_RD;
        addr_q  <= bus.req_addr[int'(grant_idx)*AW +: AW];
        wdata_q <= bus.req_wdata[int'(grant_idx)*DW +: DW];
        start_q <= 1'b1;
      end else if (issue_ok || issue_tmo) begin
        start_q <= 1'b0;
      end
      if (issue_ok && type_q == SINGLE_RD) rdata_q <= bus.single_read_data;
    end
  end

`ifdef IPIC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
  logic             tflag_q;

  assign tmo_hit = (state == ISSUE) && (tmo_cnt == CNT_W'(C_TIMEOUT_CYCLES - 1));
  assign halted  = tflag_q;

  // Watchdog: count ISSUE cycles, remember whether the access was aborted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      if (state != ISSUE)  tmo_cnt <= '0;
      else if (!tmo_hit)   tmo_cnt <= tmo_cnt + CNT_W'(1);
      if (grant_fire)      err_q   <= 1'b0;
      else if (issue_tmo)  err_q   <= 1'b1;
      if (issue_tmo)       tflag_q <= 1'b1;
    end
  end

  assign bus.req_err      = (state == RESP) && err_q;
  assign bus.timeout_flag = tflag_q;
`else
  // Without the watchdog ISSUE waits for the engine indefinitely.
  assign tmo_hit          = 1'b0;
  assign halted           = 1'b0;
  assign bus.req_err      = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.req_done   = (state == RESP) ? (C_NUM_REQ'(1) << grant_q) : '0;
  assign bus.req_rdata  = rdata_q;
  assign bus.ipic_type  = type_q;
  assign bus.ipic_start = start_q;
  assign bus.read_addr  = addr_q;
  assign bus.write_addr = addr_q;
  assign bus.write_data = wdata_q;
endmodule

// File: tb/tb_ipic_lite_arbiter.sv
// tb_ipic_lite_arbiter: directed and randomized checks of ipic_lite_arbiter
// against a transaction-level round-robin model and a behavioural IPIC engine.
module tb_ipic_lite_arbiter;
  import ipic_lite_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ipic_lite_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(N)) bus ();

  ipic_lite_arbiter #(
    .C_M_AXI_ADDR_WIDTH  (AW),
    .C_NATIVE_DATA_WIDTH (DW),
    .C_NUM_REQ           (N),
    .C_TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural IPIC engine ----------------
  bit            eng_hang  = 1'b0;
  bit            eng_force = 1'b0;
  logic [DW-1:0] eng_force_val = '0;
  logic [DW-1:0] eng_last_rd   = '0;
  int            eng_wait  = -1;

  initial begin
    bus.ipic_done        = 1'b0;
    bus.single_read_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.ipic_done = 1'b0;
        eng_wait      = -1;
      end else if (bus.ipic_done) begin
        if (!bus.ipic_start) bus.ipic_done = 1'b0;
      end else if (bus.ipic_start && !eng_hang) begin
        if (eng_wait < 0) eng_wait = $urandom_range(0, 3);
        if (eng_wait == 0) begin
          bus.single_read_data = eng_force ? eng_force_val : DW'($urandom);
          eng_last_rd          = bus.single_read_data;
          bus.ipic_done        = 1'b1;
          eng_wait             = -1;
        end else begin
          eng_wait--;
        end
      end
    end
  end

  // ---------------- requester model ----------------
  bit            txn_have [N];
  bit            txn_wr   [N];
  logic [AW-1:0] txn_addr [N];
  logic [DW-1:0] txn_data [N];
  bit            dropped  [N];
  int            active     = -1;
  int            last_grant = N - 1;
  logic [N-1:0]  prev_valid = '0;
  logic          prev_start = 1'b0;
  int            low_cnt    = 99;
  logic [DW-1:0] exp_rdata  = '0;
  int            grant_log[$];
  int            done_log[$];
  int            p_new    = 0;
  int            p_drop   = 0;
  bit            renew    = 1'b0;
  int            drop_req = -1;

  // Round-robin rule: first active requester after the last granted one.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit busy();
    busy = (active >= 0);
    for (int i = 0; i < N; i++) if (txn_have[i]) busy = 1'b1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      txn_have[i] = 1'b0;
      dropped[i]  = 1'b0;
    end
    active     = -1;
    last_grant = N - 1;
    exp_rdata  = '0;
    prev_start = 1'b0;
    low_cnt    = 99;
  endfunction

  task automatic new_txn(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_have[i] = 1'b1;
    txn_wr[i]   = wr;
    txn_addr[i] = a;
    txn_data[i] = d;
    dropped[i]  = 1'b0;
  endtask

  task automatic rand_txn(input int i);
    new_txn(i, 1'($urandom_range(0, 1)),
            32'h4000_0000 | (32'(i) << 16) | ($urandom & 32'h0000_FFFC), DW'($urandom));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]             = txn_have[i] && !dropped[i];
      bus.req_wr[i]                = txn_wr[i];
      bus.req_addr[i*AW +: AW]     = txn_addr[i];
      bus.req_wdata[i*DW +: DW]    = txn_data[i];
    end
    prev_valid = bus.req_valid;
  endtask

  // One clock: observe grants/completions at the negedge, then update requests.
  task automatic step();
    logic [N-1:0] done_v;
    int           g;
    @(negedge clk);
    done_v = bus.req_done;
    if (bus.ipic_start && !prev_start) begin
      g = rr_pick(prev_valid, last_grant);
      check("grant_expected", 64'(g >= 0), 64'(1));
      if (g >= 0) begin
        check("gap_low_cycles", 64'(low_cnt >= 3), 64'(1));
        check("ipic_type", 64'(bus.ipic_type), 64'(txn_wr[g] ? SINGLE_WR : SINGLE_RD));
        check("read_addr", 64'(bus.read_addr), 64'(txn_addr[g]));
        check("write_addr", 64'(bus.write_addr), 64'(txn_addr[g]));
        check("write_data", 64'(bus.write_data), 64'(txn_data[g]));
        check("rdata_held_at_grant", 64'(bus.req_rdata), 64'(exp_rdata));
        active     = g;
        last_grant = g;
        grant_log.push_back(g);
      end
    end
    if (bus.ipic_start) low_cnt = 0;
    else                low_cnt++;
    prev_start = bus.ipic_start;
    if (done_v != '0) begin
      check("done_has_active", 64'(active >= 0), 64'(1));
      if (active >= 0) begin
        check("req_done_onehot", 64'(done_v), 64'(1) << active);
        check("req_err", 64'(bus.req_err), 64'(0));
        if (!txn_wr[active]) exp_rdata = eng_last_rd;
        check("req_rdata", 64'(bus.req_rdata), 64'(exp_rdata));
        check("addr_stable", 64'(bus.read_addr), 64'(txn_addr[active]));
        check("start_low_in_resp", 64'(bus.ipic_start), 64'(0));
        done_log.push_back(active);
        txn_have[active] = 1'b0;
        dropped[active]  = 1'b0;
        active           = -1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (active == i && !dropped[i] &&
          (drop_req == i || $urandom_range(0, 99) < p_drop)) dropped[i] = 1'b1;
      if (!txn_have[i] && active != i && (renew || $urandom_range(0, 99) < p_new)) rand_txn(i);
    end
    drive();
  endtask

  task automatic run_until_quiet(input int budget);
    int c = 0;
    while (busy() && c < budget) begin
      step();
      c++;
    end
    check("drain_budget", 64'(busy()), 64'(0));
  endtask

  task automatic wait_grants(input int n, input int budget);
    int c = 0;
    while (grant_log.size() < n && c < budget) begin
      step();
      c++;
    end
    check("grant_budget", 64'(grant_log.size() >= n), 64'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    model_clear();
    drive();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int c;
    bit seen;
    model_clear();
    drive();

    // Reset values
    #1;
    check("rst_ipic_start", 64'(bus.ipic_start), 64'(0));
    check("rst_ipic_type", 64'(bus.ipic_type), 64'(0));
    check("rst_read_addr", 64'(bus.read_addr), 64'(0));
    check("rst_write_addr", 64'(bus.write_addr), 64'(0));
    check("rst_write_data", 64'(bus.write_data), 64'(0));
    check("rst_req_done", 64'(bus.req_done), 64'(0));
    check("rst_req_rdata", 64'(bus.req_rdata), 64'(0));
    check("rst_req_err", 64'(bus.req_err), 64'(0));
    check("rst_timeout_flag", 64'(bus.timeout_flag), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single read on requester 1
    eng_force     = 1'b1;
    eng_force_val = 32'hDEAD_BEEF;
    new_txn(1, 1'b0, 32'h4000_0010, 32'h0BAD_0001);
    drive();
    run_until_quiet(60);
    eng_force = 1'b0;
    check("rd_grant_count", 64'(grant_log.size()), 64'(1));
    check("rd_done_req", 64'(done_log.size() == 1 && done_log[0] == 1), 64'(1));
    check("rd_rdata_final", 64'(bus.req_rdata), 64'(32'hDEAD_BEEF));

    // Single write on requester 2: read data must not move
    new_txn(2, 1'b1, 32'h4000_0020, 32'h1234_5678);
    drive();
    run_until_quiet(60);
    check("wr_done_req", 64'(done_log.size() == 2 && done_log[1] == 2), 64'(1));
    check("wr_rdata_unchanged", 64'(bus.req_rdata), 64'(32'hDEAD_BEEF));
    check("wr_write_data", 64'(bus.write_data), 64'(32'h1234_5678));

    // Fairness with all requesters held high
    do_reset();
    grant_log.delete();
    done_log.delete();
    renew = 1'b1;
    for (int i = 0; i < N; i++) rand_txn(i);
    drive();
    wait_grants(8, 200);
    renew = 1'b0;
    run_until_quiet(100);
    for (int i = 0; i < 8; i++) begin
      check("fair_order", 64'(i < grant_log.size() ? grant_log[i] : -1), 64'(i % N));
    end

    // Withdrawal right after grant
    do_reset();
    grant_log.delete();
    done_log.delete();
    drop_req = 0;
    new_txn(0, 1'b0, 32'h4000_0040, 32'h0);
    drive();
    run_until_quiet(60);
    repeat (10) step();
    drop_req = -1;
    check("wd_grants", 64'(grant_log.size()), 64'(1));
    check("wd_done0", 64'(done_log.size() == 1 && done_log[0] == 0), 64'(1));

    // Reset while the engine access is outstanding
    do_reset();
    grant_log.delete();
    done_log.delete();
    eng_hang = 1'b1;
    new_txn(3, 1'b0, 32'h4000_0030, 32'h0);
    drive();
    wait_grants(1, 20);
    step();
    #2 reset_n = 1'b0;
    #1;
    check("rst_issue_start_low", 64'(bus.ipic_start), 64'(0));
    model_clear();
    drive();
    c = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.req_done != '0) c++;
    end
    check("rst_issue_no_done", 64'(c), 64'(0));
    reset_n  = 1'b1;
    eng_hang = 1'b0;
    grant_log.delete();
    for (int i = 0; i < N; i++) rand_txn(i);
    drive();
    wait_grants(1, 20);
    check("rst_issue_next_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
    run_until_quiet(200);

`ifdef IPIC_ARB_TIMEOUT_EN
    // Engine never answers: watchdog aborts after TMO ISSUE cycles
    do_reset();
    eng_hang = 1'b1;
    new_txn(1, 1'b0, 32'h4000_0100, 32'h0);
    drive();
    hi   = 0;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (bus.req_done != '0) seen = 1'b1;
      else if (bus.ipic_start) hi++;
    end
    check("tmo_done_seen", 64'(seen), 64'(1));
    check("tmo_issue_cycles", 64'(hi), 64'(TMO));
    check("tmo_done_vec", 64'(bus.req_done), 64'(4'b0010));
    check("tmo_err", 64'(bus.req_err), 64'(1));
    check("tmo_flag", 64'(bus.timeout_flag), 64'(1));
    check("tmo_start_low", 64'(bus.ipic_start), 64'(0));
    @(negedge clk);
    check("tmo_done_one_cycle", 64'(bus.req_done), 64'(0));
    new_txn(2, 1'b1, 32'h4000_0200, 32'h5555_AAAA);
    drive();
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ipic_start || bus.req_done != '0) hi++;
    end
    check("tmo_no_grant", 64'(hi), 64'(0));
    check("tmo_flag_sticky", 64'(bus.timeout_flag), 64'(1));
    eng_hang = 1'b0;
    do_reset();
    check("tmo_flag_cleared", 64'(bus.timeout_flag), 64'(0));
`else
    // Engine never answers: ISSUE holds with no error indication
    do_reset();
    eng_hang = 1'b1;
    new_txn(1, 1'b0, 32'h4000_0100, 32'h0);
    drive();
    hi = 0;
    c  = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.ipic_start) hi++;
      if (bus.req_done != '0) c++;
    end
    check("hang_start_held", 64'(hi), 64'(60));
    check("hang_no_done", 64'(c), 64'(0));
    check("hang_err_zero", 64'(bus.req_err), 64'(0));
    check("hang_flag_zero", 64'(bus.timeout_flag), 64'(0));
    eng_hang = 1'b0;
    do_reset();
`endif

    // Randomized traffic with withdrawals
    do_reset();
    grant_log.delete();
    done_log.delete();
    p_new  = 30;
    p_drop = 10;
    repeat (600) step();
    p_new  = 0;
    p_drop = 0;
    run_until_quiet(300);
    check("rand_grants_match_dones", 64'(grant_log.size()), 64'(done_log.size()));
    check("rand_traffic_seen", 64'(grant_log.size() > 20), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ipic_lite_arbiter.md
IPIC_LITE_ARBITER -- requirements
Module: ipic_lite_arbiter

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32: address width of every address port.
REQ-002 Parameter C_NATIVE_DATA_WIDTH, default 32: data width of every data port.
REQ-003 Parameter C_NUM_REQ, default 4, legal range 2..8: number of requesters.
REQ-004 Parameter C_TIMEOUT_CYCLES, default 1024: watchdog limit, used only when IPIC_ARB_TIMEOUT_EN is defined.
REQ-005 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port req_valid, input, C_NUM_REQ: per-requester request level.
REQ-008 Port req_wr, input, C_NUM_REQ: per-requester direction; 1 = single write, 0 = single read.
REQ-009 Port req_addr, input, C_NUM_REQ*ADDR: packed addresses; requester i occupies slice i.
REQ-010 Port req_wdata, input, C_NUM_REQ*DATA: packed write data.
REQ-011 Port req_done, output, C_NUM_REQ: one-cycle completion pulse per requester.
REQ-012 Port req_rdata, output, DATA: read data of the last completed read.
REQ-013 Port req_err, output, 1: error qualifier, valid while req_done is high.
REQ-014 Port ipic_type, output, 3: transaction type to the engine; 2 = single read, 3 = single write.
REQ-015 Port ipic_start, output, 1: engine start level.
REQ-016 Port ipic_done, input, 1: engine completion.
REQ-017 Port read_addr / write_addr, output, ADDR each: engine addresses.
REQ-018 Port write_data, output, DATA: engine write data.
REQ-019 Port single_read_data, input, DATA: engine read result.
REQ-020 Port timeout_flag, output, 1: sticky engine-hang indicator.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ISSUE, RESP and GAP.
REQ-022 IDLE: if any req_valid is high, the block SHALL grant round-robin (search starts at last granted + 1, modulo C_NUM_REQ; after reset it starts at requester 0), latch the granted requester's type, address and data, set ipic_start = 1 and enter ISSUE on the same edge.
REQ-023 The latched address SHALL drive both read_addr and write_addr; latched values SHALL stay stable from grant until the block returns to IDLE.
REQ-024 ISSUE: ipic_start SHALL stay high until ipic_done is sampled high. On that edge: ipic_start = 0, req_rdata is captured from single_read_data for reads (unchanged for writes), and the FSM enters RESP.
REQ-025 RESP: the FSM SHALL assert req_done[grant] for exactly one cycle, with req_err = 0, then enter GAP.
REQ-026 GAP: the FSM SHALL wait for ipic_done = 0, but at least one cycle, then enter IDLE, so the engine re-enters its idle state with ipic_start low.
REQ-027 Grant-to-ipic_start latency SHALL be 0 cycles after the grant edge; back-to-back transactions SHALL be separated by at least 3 cycles.
REQ-028 req_valid dropping after grant SHALL NOT abort the transaction; req_done is still pulsed.
REQ-029 req_valid changes during a transaction SHALL affect only the next arbitration.
REQ-030 A requester that keeps req_valid high SHALL NOT be re-granted while any other requester is waiting.
REQ-031 req_rdata SHALL hold its value until the next read completes.

Reset
REQ-032 While reset_n = 0, the block SHALL asynchronously set: state = IDLE, RR pointer to its post-reset value, ipic_start = 0, ipic_type = 0, all addresses and data = 0, req_done = 0, req_rdata = 0, req_err = 0, timeout_flag = 0.
REQ-033 Reset mid-transaction SHALL discard the transaction, with no req_done pulse.

Configuration
REQ-034 With IPIC_ARB_TIMEOUT_EN defined, a counter SHALL run in ISSUE. When it reaches C_TIMEOUT_CYCLES without ipic_done, the block SHALL set ipic_start = 0, pulse req_done[grant] with req_err = 1 and set timeout_flag, which stays set until reset.
REQ-035 With IPIC_ARB_TIMEOUT_EN defined and timeout_flag set, the block SHALL stay in IDLE and issue no further grants.
REQ-036 With IPIC_ARB_TIMEOUT_EN undefined, the block SHALL contain no counter, req_err SHALL tie to 0, timeout_flag SHALL tie to 0, and ISSUE SHALL wait indefinitely.

Structure
REQ-037 Package ipic_lite_pkg SHALL hold the type constants (SINGLE_RD = 2, SINGLE_WR = 3) and the arbiter state encoding.
REQ-038 The round-robin grant logic (request vector plus pointer in, one-hot grant out) SHALL be the sub-module ipic_rr_grant.

Verification
REQ-039 Single read: req_valid[1] with addr 0x4000_0010; engine model returns 0xDEAD_BEEF -> ipic_type = 2, read_addr = 0x4000_0010, req_done[1] one cycle, req_rdata = 0xDEAD_BEEF.
REQ-040 Single write: req_valid[2] with addr 0x4000_0020, data 0x1234_5678 -> ipic_type = 3, write_data = 0x1234_5678, req_done[2] pulse, req_rdata unchanged.
REQ-041 Fairness: all 4 req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-042 Withdrawal: req_valid[0] dropped one cycle after grant -> transaction completes, req_done[0] pulsed, requester 0 not re-granted.
REQ-043 Reset in ISSUE: reset_n low for 2 cycles -> ipic_start = 0 immediately, no req_done; next grant goes to requester 0.
REQ-044 Timeout (macro defined, C_TIMEOUT_CYCLES = 16): engine never completes -> after 16 ISSUE cycles req_done with req_err = 1, timeout_flag = 1, further requests ignored.
